// File: rtl/bullet_collision.sv
// Per-frame bullet vs alien-grid collision scan: owns the alive mask and the score.
// Optional ROW_POINTS_EN: points depend on the alien row instead of a flat POINTS.
module bullet_collision #(
   parameter int SCREEN_CORDW = 16,
   parameter int ROWS         = 5,
   parameter int COLS         = 11,
   parameter int ALIEN_W      = 32,
   parameter int ALIEN_H      = 24,
   parameter int STEP_X       = 48,
   parameter int STEP_Y       = 40,
   parameter int BULLET_W     = 40,
   parameter int BULLET_H     = 30,
   parameter int POINTS       = 10,
   parameter int SCORE_W      = 16,
   localparam int IDX_W       = $clog2(ROWS*COLS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           frame_i,
   input  logic                           new_wave_i,
   input  logic                           bullet_active_i,
   input  logic signed [SCREEN_CORDW-1:0] bullet_x_i,
   input  logic signed [SCREEN_CORDW-1:0] bullet_y_i,
   input  logic signed [SCREEN_CORDW-1:0] grid_x_i,
   input  logic signed [SCREEN_CORDW-1:0] grid_y_i,
   output logic [ROWS*COLS-1:0]           alive_mask_o,
   output logic                           bullet_rst_n_o,
   output logic                           hit_o,
   output logic [IDX_W-1:0]               hit_idx_o,
   output logic [SCORE_W-1:0]             score_o,
   output logic                           wave_clear_o,
   output logic                           busy_o
);

   // state    | meaning
   // S_IDLE   | waiting for a frame strobe with the bullet in flight
   // S_SCAN   | testing one grid index per clock, row-major
   // S_REPORT | one-clock kill report: hit pulse, bullet reset low
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

   localparam int N    = ROWS*COLS;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int W    = SCREEN_CORDW;

   localparam logic signed [W-1:0] AW_S  = W'(ALIEN_W);
   localparam logic signed [W-1:0] AH_S  = W'(ALIEN_H);
   localparam logic signed [W-1:0] BW_S  = W'(BULLET_W);
   localparam logic signed [W-1:0] BH_S  = W'(BULLET_H);
   localparam logic signed [W-1:0] SX_S  = W'(STEP_X);
   localparam logic signed [W-1:0] SY_S  = W'(STEP_Y);

   state_t                 state_q;
   logic [N-1:0]           alive_q;
   logic                   bullet_rst_n_q;
   logic                   hit_q;
   logic [IDX_W-1:0]       hit_idx_q;
   logic [SCORE_W-1:0]     score_q;
   logic                   busy_q;
   logic [IDX_W-1:0]       idx_q;
   logic [RW-1:0]          row_q;
   logic [CW-1:0]          col_q;
   logic signed [W-1:0]    bx_q, by_q, gx_q, ax_q, ay_q;

   logic signed [W-1:0]    ax_end, ay_end, bx_end, by_end;
   logic                   overlap;
   logic [7:0]             pts;
   logic [SCORE_W+7:0]     score_sum;
   logic [SCORE_W-1:0]     score_d;

   // Strict inequalities: boxes that only share an edge do not collide.
   assign ax_end  = ax_q + AW_S;
   assign ay_end  = ay_q + AH_S;
   assign bx_end  = bx_q + BW_S;
   assign by_end  = by_q + BH_S;
   assign overlap = (bx_q < ax_end) && (ax_q < bx_end) &&
                    (by_q < ay_end) && (ay_q < by_end);

   always_comb begin
`ifdef ROW_POINTS_EN
      if (row_q == '0)
         pts = 8'd30;
      else if (row_q <= RW'(2))
         pts = 8'd20;
      else
         pts = 8'd10;
`else
      pts = 8'(POINTS);
`endif
   end

   assign score_sum = {8'd0, score_q} + {{SCORE_W{1'b0}}, pts};
   assign score_d   = (score_sum > {8'd0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}}
                                                            : score_sum[SCORE_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         alive_q        <= '1;
         bullet_rst_n_q <= 1'b1;
         hit_q          <= 1'b0;
         hit_idx_q      <= '0;
         score_q        <= '0;
         busy_q         <= 1'b0;
         idx_q          <= '0;
         row_q          <= '0;
         col_q          <= '0;
         bx_q           <= '0;
         by_q           <= '0;
         gx_q           <= '0;
         ax_q           <= '0;
         ay_q           <= '0;
      end else begin
         hit_q          <= 1'b0;
         bullet_rst_n_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (frame_i && bullet_active_i && !new_wave_i) begin
                  bx_q    <= bullet_x_i;
                  by_q    <= bullet_y_i;
                  gx_q    <= grid_x_i;
                  ax_q    <= grid_x_i;
                  ay_q    <= grid_y_i;
                  idx_q   <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (new_wave_i || !bullet_active_i) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (alive_q[idx_q] && overlap) begin
                  alive_q[idx_q] <= 1'b0;
                  hit_q          <= 1'b1;
                  bullet_rst_n_q <= 1'b0;
                  hit_idx_q      <= idx_q;
                  score_q        <= score_d;
                  busy_q         <= 1'b0;
                  state_q        <= S_REPORT;
               end else if (idx_q == IDX_W'(N-1)) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
                  // Box origin is stepped incrementally instead of multiplied out.
                  if (col_q == CW'(COLS-1)) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                     ax_q  <= gx_q;
                     ay_q  <= ay_q + SY_S;
                  end else begin
                     col_q <= col_q + CW'(1);
                     ax_q  <= ax_q + SX_S;
                  end
               end
            end
            S_REPORT: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
         if (new_wave_i)
            alive_q <= '1;
      end
   end

   assign alive_mask_o   = alive_q;
   assign bullet_rst_n_o = bullet_rst_n_q;
   assign hit_o          = hit_q;
   assign hit_idx_o      = hit_idx_q;
   assign score_o        = score_q;
   assign wave_clear_o   = (alive_q == '0);
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_bullet_collision.sv
// Directed bench for bullet_collision: vector table plus hand-written corner sequences.
// A second instance with SCORE_W=4 exercises score saturation.
module tb_bullet_collision;
   localparam int N = 55;

   logic clk = 1'b0;
   logic rst;
   logic frame, new_wave, bullet_active;
   logic signed [15:0] bullet_x, bullet_y, grid_x, grid_y;

   logic [N-1:0] mask, mask4;
   logic         rstn, rstn4, hit, hit4, wclr, wclr4, busy, busy4;
   logic [5:0]   hidx, hidx4;
   logic [15:0]  score;
   logic [3:0]   score4;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_mask;
   int exp_score, exp_score4;

   always #5 clk = ~clk;

   bullet_collision dut (
      .clk(clk), .rst(rst), .frame_i(frame), .new_wave_i(new_wave),
      .bullet_active_i(bullet_active), .bullet_x_i(bullet_x), .bullet_y_i(bullet_y),
      .grid_x_i(grid_x), .grid_y_i(grid_y), .alive_mask_o(mask), .bullet_rst_n_o(rstn),
      .hit_o(hit), .hit_idx_o(hidx), .score_o(score), .wave_clear_o(wclr), .busy_o(busy));

   bullet_collision #(.SCORE_W(4)) dut4 (
      .clk(clk), .rst(rst), .frame_i(frame), .new_wave_i(new_wave),
      .bullet_active_i(bullet_active), .bullet_x_i(bullet_x), .bullet_y_i(bullet_y),
      .grid_x_i(grid_x), .grid_y_i(grid_y), .alive_mask_o(mask4), .bullet_rst_n_o(rstn4),
      .hit_o(hit4), .hit_idx_o(hidx4), .score_o(score4), .wave_clear_o(wclr4), .busy_o(busy4));

   typedef struct {
      int bx, by, gx, gy;
      int exp_idx;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int pts(input int idx);
`ifdef ROW_POINTS_EN
      int r;
      r = idx / 11;
      if (r == 0) return 30;
      else if (r <= 2) return 20;
      else return 10;
`else
      return 10;
`endif
   endfunction

   function automatic int sat(input int s, input int p, input int mx);
      return (s + p > mx) ? mx : s + p;
   endfunction

   task automatic model_kill(input int idx);
      exp_mask[idx] = 1'b0;
      exp_score  = sat(exp_score, pts(idx), 65535);
      exp_score4 = sat(exp_score4, pts(idx), 15);
   endtask

   // Frame strobe at N0; samples hit at negedges j = 1..70 after it.
   task automatic run_frame(input int bx, input int by, input int gx, input int gy,
                            output int first, output int nhits, output int idx_at,
                            output bit agree);
      @(negedge clk);
      bullet_x = 16'(bx); bullet_y = 16'(by);
      grid_x = 16'(gx); grid_y = 16'(gy);
      frame = 1'b1; bullet_active = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      first = -1; nhits = 0; idx_at = -1; agree = 1'b1;
      for (int j = 1; j <= 70; j++) begin
         if (j > 1) @(negedge clk);
         if (hit) begin
            nhits++;
            if (first < 0) begin first = j; idx_at = int'(hidx); end
         end
         if (rstn !== !hit) agree = 1'b0;
         if (hit4 !== hit || rstn4 !== rstn || busy4 !== busy || hidx4 !== hidx) agree = 1'b0;
      end
   endtask

   task automatic apply_and_check(input string tag, input vec_t v);
      int first, nhits, idx_at;
      bit agree;
      run_frame(v.bx, v.by, v.gx, v.gy, first, nhits, idx_at, agree);
      if (v.exp_idx >= 0) begin
         check({tag, "_latency"}, 64'(first), 64'(v.exp_idx + 2));
         check({tag, "_hit_idx"}, 64'(idx_at), 64'(v.exp_idx));
         model_kill(v.exp_idx);
      end
      check({tag, "_nhits"}, 64'(nhits), (v.exp_idx >= 0) ? 64'd1 : 64'd0);
      check({tag, "_rstn_dut4"}, 64'(agree), 64'd1);
      check({tag, "_mask"}, 64'(mask), 64'(exp_mask));
      check({tag, "_score"}, 64'(score), 64'(exp_score));
      check({tag, "_score4"}, 64'(score4), 64'(exp_score4));
   endtask

   initial begin
      vec_t vecs[8];
      int first, nhits, idx_at;
      bit agree;
      bit nohit;

      vecs[0] = '{100, 50, 100, 50, 0};     // direct hit on alien 0
      vecs[1] = '{120, 50, 100, 50, 1};     // overlaps 0 (dead) and 1
      vecs[2] = '{132, 50, 100, 50, -1};    // touches dead 0's right edge, misses 2
      vecs[3] = '{180, 50, 100, 50, 2};     // touches dead 1, overlaps 2
      vecs[4] = '{244, 74, 100, 50, 14};    // touches bottom of alien 3, hits row 1
      vecs[5] = '{-50, 140, -20, -10, 44};  // negative coordinates, row 4
      vecs[6] = '{-100, -100, -20, -10, -1};
      vecs[7] = '{0, 1000, 100, 50, -1};

      rst = 1'b0; frame = 1'b0; new_wave = 1'b0; bullet_active = 1'b0;
      bullet_x = '0; bullet_y = '0; grid_x = '0; grid_y = '0;
      exp_mask = '1; exp_score = 0; exp_score4 = 0;

      #12;
      check("reset_mask", 64'(mask), 64'(exp_mask));
      check("reset_rstn", 64'(rstn), 64'd1);
      check("reset_hit", 64'(hit), 64'd0);
      check("reset_hit_idx", 64'(hidx), 64'd0);
      check("reset_score", 64'(score), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_wave_clear", 64'(wclr), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++)
         apply_and_check($sformatf("vec%0d", i), vecs[i]);

      // Revive, then new_wave lands on the cycle that would enter REPORT.
      @(negedge clk); new_wave = 1'b1;
      @(negedge clk); new_wave = 1'b0;
      exp_mask = '1;
      check("revive_mask", 64'(mask), 64'(exp_mask));
      bullet_x = 16'(100); bullet_y = 16'(50); grid_x = 16'(100); grid_y = 16'(50);
      frame = 1'b1; bullet_active = 1'b1;
      @(negedge clk); frame = 1'b0; new_wave = 1'b1;
      nohit = 1'b1;
      if (hit) nohit = 1'b0;
      @(negedge clk); new_wave = 1'b0;
      check("nw_busy", 64'(busy), 64'd0);
      check("nw_mask", 64'(mask), 64'(exp_mask));
      for (int j = 0; j < 70; j++) begin
         if (hit) nohit = 1'b0;
         @(negedge clk);
      end
      check("nw_no_hit", 64'(nohit), 64'd1);
      check("nw_score", 64'(score), 64'(exp_score));

      // bullet_active drops mid-scan aimed at idx 30.
      bullet_x = 16'(484); bullet_y = 16'(130);
      frame = 1'b1;
      @(negedge clk); frame = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", 64'(busy), 64'd1);
      bullet_active = 1'b0;
      @(negedge clk);
      check("abort_busy_after", 64'(busy), 64'd0);
      nohit = 1'b1;
      for (int j = 0; j < 70; j++) begin
         if (hit) nohit = 1'b0;
         @(negedge clk);
      end
      check("abort_no_hit", 64'(nohit), 64'd1);
      check("abort_mask", 64'(mask), 64'(exp_mask));

      // Second frame strobe during a scan is ignored: idx 30 still wins.
      bullet_active = 1'b1;
      frame = 1'b1;
      @(negedge clk); frame = 1'b0;
      first = -1;
      for (int j = 1; j <= 70; j++) begin
         if (j > 1) @(negedge clk);
         if (j == 10) begin
            bullet_x = 16'(100); bullet_y = 16'(50); frame = 1'b1;
         end else begin
            frame = 1'b0;
         end
         if (hit && first < 0) begin first = j; idx_at = int'(hidx); end
      end
      check("busy_frame_latency", 64'(first), 64'd32);
      check("busy_frame_idx", 64'(idx_at), 64'd30);
      model_kill(30);
      check("busy_frame_score", 64'(score), 64'(exp_score));

      // Clear the rest of the wave one target at a time.
      for (int k = 0; k < N; k++) begin
         if (exp_mask[k]) begin
            check("wave_not_clear", 64'(wclr), 64'd0);
            run_frame(100 + (k % 11) * 48, 50 + (k / 11) * 40, 100, 50,
                      first, nhits, idx_at, agree);
            check("kill_latency", 64'(first), 64'(k + 2));
            check("kill_idx", 64'(idx_at), 64'(k));
            check("kill_agree", 64'(agree), 64'd1);
            model_kill(k);
         end
      end
      check("wave_clear", 64'(wclr), 64'd1);
      check("wave_clear4", 64'(wclr4), 64'd1);
      check("wave_mask", 64'(mask), 64'd0);
      check("wave_mask4", 64'(mask4), 64'd0);
      check("wave_score", 64'(score), 64'(exp_score));
      check("wave_score4", 64'(score4), 64'(exp_score4));

      // Asynchronous reset in the middle of a scan.
      @(negedge clk); new_wave = 1'b1;
      @(negedge clk); new_wave = 1'b0;
      bullet_x = 16'(0); bullet_y = 16'(1000); frame = 1'b1;
      @(negedge clk); frame = 1'b0;
      repeat (2) @(negedge clk);
      check("midscan_busy", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_score", 64'(score), 64'd0);
      check("rst_mask", 64'(mask), {9'd0, {N{1'b1}}});
      check("rst_hit_rstn", {62'd0, hit, rstn}, 64'd1);
      exp_mask = '1; exp_score = 0; exp_score4 = 0;
      @(negedge clk); rst = 1'b1;
      apply_and_check("post_rst", vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
